// File: rtl/io_pwr_seq_pkg.sv
// Shared definitions for the IO supply-domain power sequencer.
package io_pwr_seq_pkg;

    // Sequencer state encoding.
    typedef logic [2:0] state_t;

    localparam state_t ST_OFF       = 3'd0;
    localparam state_t ST_UP_EN     = 3'd1;
    localparam state_t ST_UP_SETTLE = 3'd2;
    localparam state_t ST_UP_REL    = 3'd3;
    localparam state_t ST_ON        = 3'd4;
    localparam state_t ST_DN_ISO    = 3'd5;
    localparam state_t ST_DN_OFF    = 3'd6;
    localparam state_t ST_ERR       = 3'd7;

    // Index width that never collapses to zero bits for a single domain.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/io_pwr_sync.sv
// Multi-stage synchroniser for a bus of independent asynchronous level signals.
module io_pwr_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    // Shift the raw inputs through the flop chain; reset reads as "not good".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/io_pwr_seq_ctrl.sv
// Power sequencer for N switchable pad-ring supply domains: ordered power-up
// (switch, power-good, settle, isolation release) and reverse power-down.
module io_pwr_seq_ctrl
    import io_pwr_seq_pkg::*;
#(
    parameter int unsigned N_DOM       = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned PG_TIMEOUT  = 1000,
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned ISO_CYC     = 4,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned IDX_W      = clog2_min1(N_DOM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwr_req_i,
    output logic             pwr_ack_o,
    output logic             busy_o,
    output logic [N_DOM-1:0] sw_en_o,
    input  logic [N_DOM-1:0] pg_i,
    output logic [N_DOM-1:0] iso_o,
    output logic             err_o,
    output logic [IDX_W-1:0] err_dom_o,
    input  logic             err_clr_i
);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_DOM - 1);
    localparam logic [CNT_W-1:0] PG_LAST     = CNT_W'(PG_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] ISO_LAST    = CNT_W'(ISO_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_DOM-1:0]   sw_en_q, sw_en_d;
    logic [N_DOM-1:0]   iso_q, iso_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   err_dom_q, err_dom_d;
    logic [N_DOM-1:0]   pg_s;

    io_pwr_sync #(
        .WIDTH  (N_DOM),
        .STAGES (SYNC_STAGES)
    ) u_pg_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pg_i),
        .q_o   (pg_s)
    );

    // Next state, index, switch/clamp outputs and counter; outputs follow the next state.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sw_en_d   = sw_en_q;
        iso_d     = iso_q;
        err_d     = err_q;
        err_dom_d = err_dom_q;

        case (state_q)
            ST_OFF: begin
                if (pwr_req_i) begin
                    state_d    = ST_UP_EN;
                    idx_d      = '0;
                    sw_en_d[0] = 1'b1;
                end
            end
            ST_UP_EN: begin
                if (!pwr_req_i) begin
                    state_d       = ST_DN_ISO;
                    iso_d[idx_q]  = 1'b1;
                end else if (pg_s[idx_q]) begin
                    state_d = ST_UP_SETTLE;
                end else if (cnt_q == PG_LAST) begin
                    state_d   = ST_ERR;
                    err_d     = 1'b1;
                    err_dom_d = idx_q;
                    sw_en_d   = '0;
                    iso_d     = '1;
                end
            end
            ST_UP_SETTLE: begin
                if (!pwr_req_i) begin
                    state_d      = ST_DN_ISO;
                    iso_d[idx_q] = 1'b1;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_UP_REL;
                end
            end
            ST_UP_REL: begin
                if (!pwr_req_i) begin
                    state_d      = ST_DN_ISO;
                    iso_d[idx_q] = 1'b1;
                end else begin
                    // Clamp drops as this state is left, giving the full up latency.
                    iso_d[idx_q] = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_ON;
                    end else begin
                        state_d                        = ST_UP_EN;
                        idx_d                          = idx_q + IDX_W'(1);
                        sw_en_d[idx_q + IDX_W'(1)]     = 1'b1;
                    end
                end
            end
            ST_ON: begin
                // A pg drop while ON is deliberately not acted upon.
                if (!pwr_req_i) begin
                    state_d         = ST_DN_ISO;
                    idx_d           = LAST_IDX;
                    iso_d[LAST_IDX] = 1'b1;
                end
            end
            ST_DN_ISO: begin
                if (pwr_req_i) begin
                    state_d        = ST_UP_EN;
                    sw_en_d[idx_q] = 1'b1;
                end else if (cnt_q == ISO_LAST) begin
                    state_d        = ST_DN_OFF;
                    sw_en_d[idx_q] = 1'b0;
                end
            end
            ST_DN_OFF: begin
                if (pwr_req_i) begin
                    state_d        = ST_UP_EN;
                    sw_en_d[idx_q] = 1'b1;
                end else if (!pg_s[idx_q] || cnt_q == PG_LAST) begin
                    // A fall timeout is flagged but the power-down carries on.
                    if (pg_s[idx_q]) begin
                        err_d     = 1'b1;
                        err_dom_d = idx_q;
                    end
                    if (idx_q == '0) begin
                        state_d = ST_OFF;
                    end else begin
                        state_d                    = ST_DN_ISO;
                        idx_d                      = idx_q - IDX_W'(1);
                        iso_d[idx_q - IDX_W'(1)]   = 1'b1;
                    end
                end
            end
            ST_ERR: begin
                sw_en_d = '0;
                iso_d   = '1;
                if (!pwr_req_i && err_clr_i) begin
                    state_d = ST_OFF;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_ERR;
                sw_en_d = '0;
                iso_d   = '1;
            end
        endcase

        ack_d  = (state_d == ST_ON);
        busy_d = !((state_d == ST_OFF) || (state_d == ST_ON) || (state_d == ST_ERR));

        // Counter measures time spent at one (state, idx) pair; saturates instead of wrapping.
        if ((state_d != state_q) || (idx_d != idx_q)) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_OFF;
            idx_q     <= '0;
            cnt_q     <= '0;
            sw_en_q   <= '0;
            iso_q     <= '1;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            err_dom_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            sw_en_q   <= sw_en_d;
            iso_q     <= iso_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            err_dom_q <= err_dom_d;
        end
    end

    assign sw_en_o   = sw_en_q;
    assign iso_o     = iso_q;
    assign pwr_ack_o = ack_q;
    assign busy_o    = busy_q;
    assign err_o     = err_q;
    assign err_dom_o = err_dom_q;

endmodule

// File: tb/tb_io_pwr_seq_ctrl.sv
// Bench for io_pwr_seq_ctrl: a pg_i plant model with random ramp delays, and
// expected event times computed from the sequencing timing rules.
module tb_io_pwr_seq_ctrl;
    import io_pwr_seq_pkg::*;

    localparam int N      = 4;
    localparam int SETTLE = 16;
    localparam int ISO    = 4;
    localparam int TMO    = 1000;
    localparam int SYNC   = 2;
    localparam int IW     = clog2_min1(N);
    // pg change (after an edge) to clamp release, in edges
    localparam int UP_LAT = SYNC + SETTLE + 2;
    // switch-off to the next step of the power-down, in edges
    localparam int DN_LAT = SYNC + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          pwr_req = 1'b0;
    logic          err_clr = 1'b0;
    logic [N-1:0]  pg = '0;
    logic          ack_o, busy_o, err_o;
    logic [N-1:0]  sw_en_o, iso_o;
    logic [IW-1:0] err_dom_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int inv_viol = 0;

    int           dly [N];
    int           on_cnt [N];
    logic [N-1:0] pg_stuck = '0;

    int           sw_rise [N], sw_fall [N], iso_rise [N], iso_fall [N], pg_rise [N];
    logic [N-1:0] sw_at_rise [N], iso_at_rise [N];
    int           ack_rise, ack_fall, busy_fall, err_rise;
    logic [N-1:0] prev_sw = '0, prev_iso = '1, prev_pg = '0;
    logic         prev_ack = 1'b0, prev_busy = 1'b0, prev_err = 1'b0;

    io_pwr_seq_ctrl #(
        .N_DOM       (N),
        .CNT_W       (16),
        .PG_TIMEOUT  (TMO),
        .SETTLE_CYC  (SETTLE),
        .ISO_CYC     (ISO),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwr_req_i (pwr_req),
        .pwr_ack_o (ack_o),
        .busy_o    (busy_o),
        .sw_en_o   (sw_en_o),
        .pg_i      (pg),
        .iso_o     (iso_o),
        .err_o     (err_o),
        .err_dom_o (err_dom_o),
        .err_clr_i (err_clr)
    );

    always #5 clk = ~clk;

    task automatic clear_events();
        for (int i = 0; i < N; i++) begin
            sw_rise[i] = -1; sw_fall[i] = -1; iso_rise[i] = -1; iso_fall[i] = -1;
            pg_rise[i] = -1; sw_at_rise[i] = 'x; iso_at_rise[i] = 'x;
        end
        ack_rise = -1; ack_fall = -1; busy_fall = -1; err_rise = -1;
    endtask

    // One clock: sample just after the edge, log output events, update the pg plant.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (sw_en_o[i] && !prev_sw[i]) begin sw_rise[i] = cyc; sw_at_rise[i] = sw_en_o; end
            if (!sw_en_o[i] && prev_sw[i]) sw_fall[i] = cyc;
            if (iso_o[i] && !prev_iso[i]) begin iso_rise[i] = cyc; iso_at_rise[i] = iso_o; end
            if (!iso_o[i] && prev_iso[i]) iso_fall[i] = cyc;
            if (!iso_o[i] && !sw_en_o[i]) inv_viol++;
            if (sw_en_o[i] === 1'b1) begin
                if (on_cnt[i] <= dly[i]) on_cnt[i]++;
            end else begin
                on_cnt[i] = 0;
            end
            pg[i] = (on_cnt[i] > dly[i]) && !pg_stuck[i];
            if (pg[i] && !prev_pg[i]) pg_rise[i] = cyc;
        end
        if (ack_o && !prev_ack) ack_rise = cyc;
        if (!ack_o && prev_ack) ack_fall = cyc;
        if (!busy_o && prev_busy) busy_fall = cyc;
        if (err_o && !prev_err) err_rise = cyc;
        prev_sw = sw_en_o; prev_iso = iso_o; prev_pg = pg;
        prev_ack = ack_o; prev_busy = busy_o; prev_err = err_o;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (sw_en_o !== '0) begin errors++; $display("FAIL rst_sw_en: got %b want 0000", sw_en_o); end
        checks++; if (iso_o !== '1) begin errors++; $display("FAIL rst_iso: got %b want 1111", iso_o); end
        checks++; if ({ack_o, busy_o, err_o} !== 3'b000) begin errors++; $display("FAIL rst_flags: ack/busy/err got %b want 000", {ack_o, busy_o, err_o}); end
        checks++; if (err_dom_o !== '0) begin errors++; $display("FAIL rst_err_dom: got %0d want 0", err_dom_o); end
        @(posedge clk); #3 rst_n = 1'b1;
        run(3);
        checks++; if (sw_en_o !== '0 || busy_o !== 1'b0) begin errors++; $display("FAIL idle_off: sw=%b busy=%b want 0000/0", sw_en_o, busy_o); end
    endtask

    task automatic test_full_up(input bit rnd);
        int c0, t, k;
        logic [N-1:0] therm;
        for (int i = 0; i < N; i++) dly[i] = rnd ? int'($urandom_range(1, 8)) : 5;
        clear_events();
        c0 = cyc; pwr_req = 1'b1; k = 0;
        while (ack_o !== 1'b1 && k < 800) begin step(); k++; end
        t = c0 + 1;
        for (int i = 0; i < N; i++) begin
            therm = N'((1 << (i + 1)) - 1);
            checks++; if (sw_rise[i] !== t) begin errors++; $display("FAIL up_sw_rise[%0d]: got cyc %0d want %0d", i, sw_rise[i], t); end
            checks++; if (sw_at_rise[i] !== therm) begin errors++; $display("FAIL up_sw_order[%0d]: got %b want %b", i, sw_at_rise[i], therm); end
            t = t + dly[i] + UP_LAT;
            checks++; if (iso_fall[i] !== t) begin errors++; $display("FAIL up_iso_fall[%0d]: got cyc %0d want %0d", i, iso_fall[i], t); end
        end
        checks++; if (ack_rise !== t) begin errors++; $display("FAIL up_ack_rise: got cyc %0d want %0d", ack_rise, t); end
        checks++; if (iso_o !== '0 || sw_en_o !== '1 || busy_o !== 1'b0) begin errors++; $display("FAIL up_on_state: iso=%b sw=%b busy=%b want 0000/1111/0", iso_o, sw_en_o, busy_o); end
    endtask

    task automatic test_full_down();
        int c0, t, k;
        logic [N-1:0] pat;
        clear_events();
        c0 = cyc; pwr_req = 1'b0;
        step(); k = 1;
        while (busy_o === 1'b1 && k < 400) begin step(); k++; end
        checks++; if (ack_fall !== c0 + 1) begin errors++; $display("FAIL dn_ack_fall: got cyc %0d want %0d", ack_fall, c0 + 1); end
        t = c0 + 1;
        for (int i = N - 1; i >= 0; i--) begin
            pat = ~N'((1 << i) - 1);
            checks++; if (iso_rise[i] !== t) begin errors++; $display("FAIL dn_iso_rise[%0d]: got cyc %0d want %0d", i, iso_rise[i], t); end
            checks++; if (iso_at_rise[i] !== pat) begin errors++; $display("FAIL dn_iso_order[%0d]: got %b want %b", i, iso_at_rise[i], pat); end
            t = t + ISO;
            checks++; if (sw_fall[i] !== t) begin errors++; $display("FAIL dn_sw_fall[%0d]: got cyc %0d want %0d", i, sw_fall[i], t); end
            t = t + DN_LAT;
        end
        checks++; if (busy_fall !== t) begin errors++; $display("FAIL dn_off_entry: got cyc %0d want %0d", busy_fall, t); end
        checks++; if (sw_en_o !== '0 || iso_o !== '1 || ack_o !== 1'b0) begin errors++; $display("FAIL dn_off_state: sw=%b iso=%b ack=%b", sw_en_o, iso_o, ack_o); end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            test_full_up(1'b1);
            test_full_down();
        end
    endtask

    task automatic test_timeout();
        int c0, t, k;
        for (int i = 0; i < N; i++) dly[i] = int'($urandom_range(1, 8));
        pg_stuck = 4'b0100;
        clear_events();
        c0 = cyc; pwr_req = 1'b1; k = 0;
        while (err_o !== 1'b1 && k < 1500) begin step(); k++; end
        t = c0 + 1 + dly[0] + UP_LAT + dly[1] + UP_LAT;
        checks++; if (sw_rise[2] !== t) begin errors++; $display("FAIL tmo_dom2_en: got cyc %0d want %0d", sw_rise[2], t); end
        checks++; if (err_rise !== t + TMO) begin errors++; $display("FAIL tmo_err_time: got cyc %0d want %0d", err_rise, t + TMO); end
        checks++; if (err_dom_o !== IW'(2)) begin errors++; $display("FAIL tmo_err_dom: got %0d want 2", err_dom_o); end
        checks++; if (sw_en_o !== '0 || iso_o !== '1) begin errors++; $display("FAIL tmo_safe: sw=%b iso=%b want 0000/1111", sw_en_o, iso_o); end
        checks++; if (busy_o !== 1'b0 || ack_o !== 1'b0) begin errors++; $display("FAIL tmo_flags: busy=%b ack=%b want 0/0", busy_o, ack_o); end
        err_clr = 1'b1;
        run(5);
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL tmo_clr_ignored: err=%b want 1", err_o); end
        pwr_req = 1'b0;
        step();
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL tmo_clr: err=%b want 0", err_o); end
        err_clr = 1'b0; pg_stuck = '0;
        run(4);
        checks++; if (sw_en_o !== '0 || busy_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL tmo_off: sw=%b busy=%b err=%b", sw_en_o, busy_o, err_o); end
    endtask

    task automatic test_rev_up();
        int s, k, t;
        for (int i = 0; i < N; i++) dly[i] = int'($urandom_range(1, 8));
        clear_events();
        pwr_req = 1'b1; k = 0;
        while (pg_rise[1] == -1 && k < 300) begin step(); k++; end
        s = pg_rise[1] + SYNC + 1 + int'($urandom_range(0, SETTLE - 1));
        k = 0;
        while (cyc < s && k < 100) begin step(); k++; end
        pwr_req = 1'b0;
        step(); k = 1;
        while (busy_o === 1'b1 && k < 300) begin step(); k++; end
        t = s + 1 + ISO;
        checks++; if (sw_fall[1] !== t) begin errors++; $display("FAIL rev_up_sw1_off: got cyc %0d want %0d", sw_fall[1], t); end
        checks++; if (iso_rise[0] !== t + DN_LAT) begin errors++; $display("FAIL rev_up_iso0: got cyc %0d want %0d", iso_rise[0], t + DN_LAT); end
        t = t + DN_LAT + ISO;
        checks++; if (sw_fall[0] !== t) begin errors++; $display("FAIL rev_up_sw0_off: got cyc %0d want %0d", sw_fall[0], t); end
        checks++; if (busy_fall !== t + DN_LAT) begin errors++; $display("FAIL rev_up_off: got cyc %0d want %0d", busy_fall, t + DN_LAT); end
        checks++; if (iso_fall[1] !== -1 || sw_rise[2] !== -1) begin errors++; $display("FAIL rev_up_dom1_held: iso1 fall cyc %0d sw2 rise cyc %0d want -1/-1", iso_fall[1], sw_rise[2]); end
        checks++; if (sw_en_o !== '0 || iso_o !== '1) begin errors++; $display("FAIL rev_up_end: sw=%b iso=%b", sw_en_o, iso_o); end
    endtask

    task automatic test_rev_down();
        int k, rr;
        test_full_up(1'b1);
        clear_events();
        pwr_req = 1'b0; k = 0;
        while (sw_fall[3] == -1 && k < 100) begin step(); k++; end
        run(int'($urandom_range(0, DN_LAT - 1)));
        pwr_req = 1'b1; rr = cyc; k = 0;
        while (ack_o !== 1'b1 && k < 600) begin step(); k++; end
        checks++; if (sw_rise[3] !== rr + 1) begin errors++; $display("FAIL rev_dn_sw3_back: got cyc %0d want %0d", sw_rise[3], rr + 1); end
        checks++; if (sw_fall[2] !== -1) begin errors++; $display("FAIL rev_dn_dom2_kept: sw2 fell at cyc %0d want never", sw_fall[2]); end
        checks++; if (ack_o !== 1'b1 || iso_o !== '0 || sw_en_o !== '1) begin errors++; $display("FAIL rev_dn_on: ack=%b iso=%b sw=%b want 1/0000/1111", ack_o, iso_o, sw_en_o); end
        test_full_down();
    endtask

    task automatic test_reset_mid();
        int k;
        for (int i = 0; i < N; i++) dly[i] = 5;
        clear_events();
        pwr_req = 1'b1; k = 0;
        while (pg_rise[2] == -1 && k < 300) begin step(); k++; end
        run(SYNC + 1 + int'($urandom_range(0, SETTLE - 1)));
        checks++; if (busy_o !== 1'b1 || iso_o[2] !== 1'b1 || sw_en_o !== 4'b0111) begin errors++; $display("FAIL mid_pre: busy=%b iso=%b sw=%b", busy_o, iso_o, sw_en_o); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (sw_en_o !== '0 || iso_o !== '1 || ack_o !== 1'b0) begin errors++; $display("FAIL mid_rst_async: sw=%b iso=%b ack=%b want 0000/1111/0", sw_en_o, iso_o, ack_o); end
        pwr_req = 1'b0;
        #10 rst_n = 1'b1;
        run(4);
        checks++; if (sw_en_o !== '0 || busy_o !== 1'b0) begin errors++; $display("FAIL mid_after: sw=%b busy=%b want 0000/0", sw_en_o, busy_o); end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin dly[i] = 5; on_cnt[i] = 0; end
        clear_events();
        test_reset();
        test_full_up(1'b0);
        test_full_down();
        test_back_to_back();
        test_timeout();
        test_rev_up();
        test_rev_down();
        test_reset_mid();
        checks++; if (inv_viol !== 0) begin errors++; $display("FAIL iso_invariant: %0d samples with iso=0 and sw_en=0, want 0", inv_viol); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
